// File: rtl/uart_tx_unit.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, programmable stop period.
// All bit timing is counted in 16x-oversampling baud ticks supplied on s_tick.
module uart_tx_unit #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            par, par_next;
  logic            tx_next;
  logic            done_next;

  // Parity is taken from the word as accepted, before any shifting.
  function automatic logic parity_of(input logic [DBIT-1:0] w);
    return (PARITY == 2) ? ~(^w) : (^w);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      par          <= 1'b0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_next;
      s            <= s_next;
      n            <= n_next;
      b            <= b_next;
      par          <= par_next;
      tx           <= tx_next;
      tx_done_tick <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    par_next   = par;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          b_next     = din;
          par_next   = parity_of(din);
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_next = '0;
            b_next = b >> 1;
            if (n == N_LAST) begin
              state_next = (PARITY != 0) ? PAR : STOP;
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP_LAST) begin
            s_next     = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level follows the state being entered so tx changes on the same edge as state.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      PAR:     tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx_busy = (state != IDLE);

endmodule

// File: doc/uart_tx_unit.md
# uart_tx_unit

Serial transmitter for the MCS I/O subsystem's UART core. It converts a parallel word into an asynchronous serial frame: start bit, DBIT data bits LSB first, an optional parity bit, and a programmable stop period. All bit timing comes from an external 16x-oversampling baud tick; the baud-rate generator is not part of this block. It pairs with the UART receiver, which samples frames in the same tick domain.

## Interface
- DBIT, default 8: data bits per frame, legal 5..9.
- SB_TICK, default 16: baud ticks in the stop period. 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.
- PARITY, default 0: 0 none, 1 even, 2 odd.
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- s_tick  input  1  one-clk baud-oversample enable, 16 per bit period.
- tx_start  input  1  request to send `din`; sampled only in IDLE.
- din  input  DBIT  word to transmit; captured on the accepting edge.
- tx_busy  output  1  high in every state except IDLE.
- tx_done_tick  output  1  one-clk pulse when a frame completes.
- tx  output  1  serial line; idle high.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- Registers:
  - state
  - 4-bit tick counter s
  - bit counter n, width clog2(DBIT)
  - DBIT shift register b
  - registered tx
  - registered tx_done_tick
- IDLE:
  - tx=1.
  - If tx_start=1, then b←din, s←0, and state→START. s_tick is not required.
  - tx_start in any other state is ignored; din is not re-read.
- START:
  - tx=0.
  - On each s_tick, s increments.
  - When s_tick arrives with s=15: s←0, n←0, state→DATA.
- DATA:
  - tx=b[0].
  - When s_tick arrives with s=15: s←0 and b shifts right by one.
  - If n=DBIT-1, state→PAR when PARITY≠0, otherwise state→STOP. Else n←n+1.
- PAR:
  - tx = XOR of the captured word for even parity, or its complement for odd parity.
  - Parity is computed from the word captured at acceptance, not from the shifted b.
  - After 16 ticks, state→STOP.
- STOP:
  - tx=1.
  - When s_tick arrives with s=SB_TICK-1: state→IDLE and tx_done_tick←1 for the next cycle only.
  - The s width must hold SB_TICK-1; widen s to 5 bits when SB_TICK>16.
- tx is driven from a register updated on the same edge as state, so it is glitch-free and always reflects the current state's bit.
- Reset (reset_n=0, at any time, including mid-frame):
  - Immediately forces state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, and s=n=b=0.
  - No done pulse is produced for an aborted frame.

## Timing
- Acceptance latency: tx_start high in IDLE at cycle k gives tx=0 and tx_busy=1 from cycle k+1.
- Each bit lasts exactly 16 s_ticks, and the stop period lasts SB_TICK s_ticks, regardless of the clk/s_tick ratio.
- Frame length in ticks = 16·(1+DBIT+(PARITY≠0)) + SB_TICK. For the defaults this is 160.
- tx_done_tick is high in the first IDLE cycle after the frame, coincident with tx_busy=0.
- Back-to-back: tx_start high in the tx_done_tick cycle is accepted, so the next start bit begins on the following cycle with no extra idle time.
- s_tick asserted during IDLE has no effect.
- s_tick held continuously high counts one tick per clk.

## Test plan
- Defaults, s_tick=1 every cycle, din=8'hA5, tx_start at cycle 0:
  - tx=0 for cycles 1–16.
  - Data bits 1,0,1,0,0,1,0,1, each 16 cycles, over cycles 17–144.
  - tx=1 for cycles 145–160.
  - tx_done_tick=1 only at cycle 161.
  - tx_busy=1 for cycles 1–160.
- s_tick every 4th cycle, din=8'h3C: every bit lasts 64 clks, and the receiver model recovers 8'h3C.
- PARITY=1, din=8'h07 gives parity bit 1. PARITY=2 with the same data gives 0. PARITY=1, din=8'h00 gives 0.
- SB_TICK=32, DBIT=7, din=7'h55: frame is 16·8+32=160 ticks, the stop period is high for 32 ticks, and the done pulse follows.
- Pulse tx_start at cycle 50 of an active frame with a different din: the frame is unchanged and there is no second frame. Then raise tx_start in the done cycle: the new start bit begins at the next cycle.
- Drop reset_n at cycle 70 of a frame: tx=1 and tx_busy=0 asynchronously, and there is no tx_done_tick. After release, a new tx_start sends a full, correct frame.
